// File: rtl/tetris_pkg.sv
// Shared piece encoding and bag helpers for the block-drop game.
package tetris_pkg;
    localparam int NUM_PIECES = 7;

    typedef enum logic [2:0] {
        PIECE_I    = 3'd0,
        PIECE_O    = 3'd1,
        PIECE_T    = 3'd2,
        PIECE_J    = 3'd3,
        PIECE_L    = 3'd4,
        PIECE_S    = 3'd5,
        PIECE_Z    = 3'd6,
        PIECE_NONE = 3'd7
    } piece_t;

    // Lowest-index piece not yet drawn from the bag.
    function automatic piece_t first_unused(input logic [NUM_PIECES-1:0] used);
        first_unused = PIECE_NONE;
        for (int i = NUM_PIECES - 1; i >= 0; i--)
            if (!used[i]) first_unused = piece_t'(i[2:0]);
    endfunction
endpackage

// File: rtl/next_piece_gen_fifo.sv
// Shift-register piece FIFO: slot 0 is the oldest entry, unused slots hold PIECE_NONE.
module piece_fifo
    import tetris_pkg::*;
#(
    parameter  int DEPTH = 6,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  piece_t               push_data,
    input  logic                 pop,
    output piece_t [DEPTH-1:0]   slots,
    output logic   [CW-1:0]      count
);
    piece_t [DEPTH-1:0] mem, mem_nxt;
    logic   [CW-1:0]    cnt_nxt, wr_idx;
    logic               do_pop, do_push;

    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && (do_pop || count != CW'(DEPTH));
        mem_nxt = mem;
        cnt_nxt = count;
        wr_idx  = count;
        if (do_pop) begin
            for (int k = 0; k < DEPTH - 1; k++) mem_nxt[k] = mem[k+1];
            mem_nxt[DEPTH-1] = PIECE_NONE;
            wr_idx  = count - CW'(1);
            cnt_nxt = count - CW'(1);
        end
        // A push during a pop lands where the shifted tail now ends.
        if (do_push) begin
            for (int k = 0; k < DEPTH; k++)
                if (wr_idx == CW'(k)) mem_nxt[k] = push_data;
            cnt_nxt = cnt_nxt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= PIECE_NONE;
            count <= '0;
        end else begin
            mem   <= mem_nxt;
            count <= cnt_nxt;
        end
    end

    assign slots = mem;
endmodule

// File: rtl/next_piece_gen.sv
// Seven-bag randomizer: builds 3-bit candidates from the LFSR stream, rejects
// repeats within a bag, and queues accepted pieces for play and preview.
module next_piece_gen
    import tetris_pkg::*;
#(
    parameter  int DEPTH = 6,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rand_bit,
    input  logic                 piece_req,
    output logic                 piece_valid,
    output piece_t               piece,
    output piece_t [DEPTH-1:0]   queue,
    output logic   [CW-1:0]      count
);
    logic [1:0]            acc, bcnt;
    logic [NUM_PIECES-1:0] bag_used;
    logic [2:0]            cand;
    logic [7:0]            used_ext, cand_onehot;
    logic                  full, fill_mode, accept, push;
    piece_t                push_piece;

    assign full        = (count == CW'(DEPTH));
    assign fill_mode   = ($countones(bag_used) == 6);
    assign cand        = {acc, rand_bit};
    // Code 7 is treated as permanently used so one lookup rejects both cases.
    assign used_ext    = {1'b1, bag_used};
    assign cand_onehot = 8'b1 << cand;
    assign accept      = (bcnt == 2'd2) && !used_ext[cand];

    always_comb begin
        push       = 1'b0;
        push_piece = PIECE_NONE;
        if (!full) begin
            if (fill_mode) begin
                push       = 1'b1;
                push_piece = first_unused(bag_used);
            end else if (accept) begin
                push       = 1'b1;
                push_piece = piece_t'(cand);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            bcnt     <= '0;
            bag_used <= '0;
        end else if (!full) begin
            if (fill_mode) begin
                bag_used <= '0;
            end else if (bcnt == 2'd2) begin
                bcnt <= '0;
                if (accept) bag_used <= bag_used | cand_onehot[NUM_PIECES-1:0];
            end else begin
                acc  <= {acc[0], rand_bit};
                bcnt <= bcnt + 2'd1;
            end
        end
    end

    piece_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_piece),
        .pop       (piece_req),
        .slots     (queue),
        .count     (count)
    );

    assign piece_valid = (count != '0);
    assign piece       = queue[0];
endmodule

// File: tb/tb_next_piece_gen.sv
// Randomized and directed checks of next_piece_gen against a queue-based bag model.
module tb_next_piece_gen;
    localparam int DEPTH = 6;
    localparam int CW    = $clog2(DEPTH + 1);
    typedef logic [DEPTH-1:0][2:0] qv_t;

    logic          clk, rst, rand_bit, piece_req;
    logic          piece_valid;
    logic [2:0]    piece;
    qv_t           queue;
    logic [CW-1:0] count;

    int total = 0;
    int bad   = 0;

    next_piece_gen #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .rand_bit    (rand_bit),
        .piece_req   (piece_req),
        .piece_valid (piece_valid),
        .piece       (piece),
        .queue       (queue),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending bits as a list, bag as a set of flags, FIFO as a queue.
    logic [2:0] mq[$];
    bit         mused[7];
    bit         mbits[$];

    task automatic model_reset();
        mq.delete();
        mbits.delete();
        foreach (mused[i]) mused[i] = 1'b0;
    endtask

    task automatic model_step(input bit rb, input bit rq);
        int n, v;
        bit pushf;
        logic [2:0] pv;
        n = 0; pushf = 0; pv = 3'd7;
        foreach (mused[i]) n += int'(mused[i]);
        if (mq.size() < DEPTH) begin
            if (n == 6) begin
                for (int i = 0; i < 7; i++) if (!mused[i]) pv = i[2:0];
                foreach (mused[i]) mused[i] = 1'b0;
                pushf = 1;
            end else begin
                mbits.push_back(rb);
                if (mbits.size() == 3) begin
                    v = int'(mbits[0]) * 4 + int'(mbits[1]) * 2 + int'(mbits[2]);
                    mbits.delete();
                    if (v < 7 && !mused[v]) begin
                        mused[v] = 1'b1;
                        pv = v[2:0];
                        pushf = 1;
                    end
                end
            end
        end
        if (rq && mq.size() > 0) void'(mq.pop_front());
        if (pushf) mq.push_back(pv);
    endtask

    function automatic qv_t exp_queue();
        qv_t r;
        for (int k = 0; k < DEPTH; k++) r[k] = (k < mq.size()) ? mq[k] : 3'd7;
        return r;
    endfunction

    task automatic step(input bit rb, input bit rq);
        rand_bit  = rb;
        piece_req = rq;
        @(posedge clk);
        model_step(rb, rq);
        @(negedge clk);
        piece_req = 1'b0;
    endtask

    task automatic draw(input int p);
        logic [2:0] b;
        b = p[2:0];
        step(b[2], 0); step(b[1], 0); step(b[0], 0);
    endtask

    task automatic apply_reset();
        rst = 1'b1; rand_bit = 1'b0; piece_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; rand_bit = 1'b0; piece_req = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (count !== '0 || piece_valid !== 1'b0 || piece !== 3'd7 || queue !== {DEPTH{3'd7}}) begin
            bad++;
            $display("FAIL reset count=%0d valid=%0b piece=%0d queue=%h exp 0/0/7/all7", count, piece_valid, piece, queue);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_first_draw();
        apply_reset();
        step(0, 0); step(1, 0);
        total++;
        if (count !== '0) begin bad++; $display("FAIL first_draw_early count got=%0d exp=0", count); end
        step(0, 0);
        total++;
        if (piece !== 3'd2 || count !== CW'(1) || piece_valid !== 1'b1) begin
            bad++; $display("FAIL first_draw piece=%0d count=%0d valid=%0b exp 2/1/1", piece, count, piece_valid);
        end
        total++;
        if (queue !== exp_queue()) begin bad++; $display("FAIL first_draw_queue got=%h exp=%h", queue, exp_queue()); end
    endtask

    task automatic test_reject_range();
        step(1, 0); step(1, 0); step(1, 0);
        total++;
        if (count !== CW'(1)) begin bad++; $display("FAIL reject_range count got=%0d exp=1", count); end
        step(1, 0); step(1, 0); step(0, 0);
        total++;
        if (count !== CW'(2) || queue[1] !== 3'd6) begin
            bad++; $display("FAIL after_reject count=%0d q1=%0d exp 2/6", count, queue[1]);
        end
    endtask

    task automatic test_duplicate();
        apply_reset();
        draw(3); draw(3);
        total++;
        if (count !== CW'(1) || piece !== 3'd3) begin
            bad++; $display("FAIL duplicate count=%0d piece=%0d exp 1/3", count, piece);
        end
    endtask

    task automatic test_bag_completion();
        qv_t snap;
        apply_reset();
        for (int p = 0; p < 6; p++) draw(p);
        snap = queue;
        total++;
        if (count !== CW'(6) || queue !== exp_queue()) begin
            bad++; $display("FAIL bag_full count=%0d queue=%h exp 6/%h", count, queue, exp_queue());
        end
        for (int i = 0; i < 10; i++) step(1'($urandom_range(0, 1)), 0);
        total++;
        if (count !== CW'(6) || queue !== snap) begin
            bad++; $display("FAIL full_hold count=%0d queue=%h exp 6/%h", count, queue, snap);
        end
        step(0, 1);
        total++;
        if (piece !== 3'd1 || count !== CW'(5)) begin
            bad++; $display("FAIL full_pop piece=%0d count=%0d exp 1/5", piece, count);
        end
        step(0, 0);
        total++;
        if (count !== CW'(6) || queue[5] !== 3'd6) begin
            bad++; $display("FAIL fill_push count=%0d q5=%0d exp 6/6", count, queue[5]);
        end
        step(0, 1);
        draw(6);
        total++;
        if (count !== CW'(6) || queue[5] !== 3'd6 || queue !== exp_queue()) begin
            bad++; $display("FAIL new_bag count=%0d queue=%h exp 6/%h", count, queue, exp_queue());
        end
    endtask

    task automatic test_overlap();
        apply_reset();
        draw(0); draw(1); draw(2);
        step(1, 0); step(0, 0); step(0, 1);
        total++;
        if (count !== CW'(3) || queue[2] !== 3'd4 || piece !== 3'd1) begin
            bad++; $display("FAIL overlap count=%0d q2=%0d piece=%0d exp 3/4/1", count, queue[2], piece);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int p = 0; p < 4; p++) draw(p);
        step(1, 0);
        rst = 1'b1;
        #1;
        total++;
        if (count !== '0 || piece_valid !== 1'b0 || piece !== 3'd7 || queue !== {DEPTH{3'd7}}) begin
            bad++; $display("FAIL async_reset count=%0d valid=%0b piece=%0d queue=%h exp 0/0/7/all7", count, piece_valid, piece, queue);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(0, 0); step(1, 0);
        total++;
        if (count !== '0) begin bad++; $display("FAIL post_reset_early count got=%0d exp=0", count); end
        step(0, 0);
        total++;
        if (count !== CW'(1) || piece !== 3'd2) begin
            bad++; $display("FAIL post_reset_push count=%0d piece=%0d exp 1/2", count, piece);
        end
    endtask

    task automatic test_random();
        bit rb, rq;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            rb = 1'($urandom_range(0, 1));
            rq = ($urandom_range(0, 9) < 3);
            step(rb, rq);
            total++;
            if (count !== CW'(mq.size()) || piece_valid !== (mq.size() != 0) || queue !== exp_queue()) begin
                bad++;
                $display("FAIL random cyc=%0d count=%0d queue=%h exp %0d/%h", i, count, queue, mq.size(), exp_queue());
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_draw();
        test_reject_range();
        test_duplicate();
        test_bag_completion();
        test_overlap();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
